comp_alarm_fsm: RTL and testbench
=================================

Name: comp_alarm_fsm

Overview:
- Downstream consumer of the 4-bit magnitude comparator's less/equal/greater outputs.
- Turns the per-sample comparison results into a debounced, hysteretic "a exceeds b" alarm.
- Keeps saturating per-outcome statistics counters.
- Sits between the comparator and the status/interrupt logic; one sample is accepted per cycle when in_valid is high.

Parameters:
- SET_CNT, 3, consecutive valid "greater" samples needed to raise the alarm (legal range 1..15).
- CLR_CNT, 2, consecutive valid "less or equal" samples needed to drop the alarm (legal range 1..15).
- CNT_W, 8, width of each statistics counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  comparator result on less/equal/greater is valid this cycle.
- less  input  1  comparator result: a < b.
- equal  input  1  comparator result: a == b.
- greater  input  1  comparator result: a > b.
- clr_stats  input  1  synchronous clear of the statistics counters.
- alarm  output  1  debounced alarm level.
- alarm_rise  output  1  one-cycle pulse when alarm goes 0->1.
- state  output  2  FSM state: 0 IDLE, 1 ARMING, 2 ALARM, 3 CLEARING.
- gt_cnt  output  CNT_W  count of valid "greater" samples.
- lt_cnt  output  CNT_W  count of valid "less" samples.
- eq_cnt  output  CNT_W  count of valid "equal" samples.
- err  output  1  one-cycle pulse on a valid sample that is not one-hot.
- alarm_seen  output  1  sticky alarm flag (see Optional Feature).

Behaviour:
- Clocking and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, internal 4-bit run counter 0.
- Latency and registering: every output is registered; a sample at edge N is reflected in the outputs after edge N.
- Sample classes:
  - A sample is "good" when in_valid=1 and exactly one of less/equal/greater is 1.
  - "gt" means greater=1; "le" means less=1 or equal=1.
- Bad samples (in_valid=1 but not one-hot, including all-zero):
  - err pulses for one cycle.
  - FSM, run counter and statistics counters are unchanged.
- No sample (in_valid=0): FSM and run counter hold; err=0.
- FSM transitions, good samples only:
  - IDLE, gt: run=1. Go to ALARM if SET_CNT==1 (run=0), otherwise go to ARMING.
  - IDLE, le: stay in IDLE, run=0.
  - ARMING, gt: run=run+1. When run+1==SET_CNT, go to ALARM and set run=0.
  - ARMING, le: go to IDLE, run=0.
  - ALARM, le: run=1. Go to IDLE if CLR_CNT==1 (run=0), otherwise go to CLEARING.
  - ALARM, gt: stay in ALARM, run=0.
  - CLEARING, le: run=run+1. When run+1==CLR_CNT, go to IDLE and set run=0.
  - CLEARING, gt: go back to ALARM, run=0.
- Alarm outputs:
  - alarm=1 exactly when the registered state is ALARM or CLEARING.
  - alarm_rise=1 for the single cycle after the transition into ALARM from IDLE or ARMING. It is not asserted on CLEARING->ALARM.
- Statistics counters:
  - A good sample increments its class counter by 1.
  - Each counter saturates at all-ones; no wrap-around.
- clr_stats:
  - Zeroes all three counters.
  - If asserted in the same cycle as a good sample, the clear wins and the sample is not counted.
  - The FSM still processes that sample.
- Reset mid-operation: rst overrides everything, including an in-flight ARMING/CLEARING run. The next cycle starts in IDLE.

Optional Feature:
- Macro: COMP_ALARM_STICKY_EN.
- Defined: alarm_seen is set on any cycle alarm_rise is set. It is cleared only by rst or clr_stats; clr_stats wins over a simultaneous rise.
- Not defined: alarm_seen is tied to 0 and no sticky register is built.

Test Plan (SET_CNT=3, CLR_CNT=2, CNT_W=8):
- Debounced raise: reset, then 3 consecutive valid greater samples -> state 0->1->1->2; alarm=1 and alarm_rise=1 after the 3rd edge only; gt_cnt=3.
- Interrupted arming: gt, gt, equal, gt -> state goes back to IDLE on equal; no alarm; gt_cnt=3, eq_cnt=1.
- Hysteresis: from ALARM, less then greater then less, less -> CLEARING, ALARM (no alarm_rise), CLEARING, IDLE; alarm stays 1 until the final edge.
- Bad input and gaps: in_valid=1 with less=1 and greater=1, then in_valid=1 with all zero, then in_valid=0 -> err pulses on the first two cycles; counters and state unchanged throughout.
- Saturation and clear: 300 greater samples -> gt_cnt=255; clr_stats together with a greater sample -> gt_cnt=0, state stays ALARM.
- Sticky flag (macro defined): raise the alarm, then clear it via 2 less samples -> alarm_seen=1 persists until clr_stats; a synchronous rst mid-ARMING -> all outputs 0 next cycle.

Source files
------------

// File: rtl/comp_alarm_fsm.sv
// Debounced, hysteretic "a exceeds b" alarm driven by a magnitude comparator, with saturating outcome counters.
// Optional sticky alarm_seen flag is built only when COMP_ALARM_STICKY_EN is defined.
module comp_alarm_fsm #(
    parameter int SET_CNT = 3,
    parameter int CLR_CNT = 2,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             less,
    input  logic             equal,
    input  logic             greater,
    input  logic             clr_stats,
    output logic             alarm,
    output logic             alarm_rise,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic             err,
    output logic             alarm_seen
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMING   = 2'd1,
        ALARM    = 2'd2,
        CLEARING = 2'd3
    } state_t;

    localparam logic [3:0] SET_N = 4'(SET_CNT);
    localparam logic [3:0] CLR_N = 4'(CLR_CNT);

    state_t           state_q, state_d;
    logic [3:0]       run_q, run_d;
    logic             rise_q, rise_d;
    logic             err_q;
    logic [CNT_W-1:0] gt_q, lt_q, eq_q;
    logic             onehot, good, bad, is_gt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign onehot = ({less, equal, greater} == 3'b100) ||
                    ({less, equal, greater} == 3'b010) ||
                    ({less, equal, greater} == 3'b001);
    assign good   = in_valid && onehot;
    assign bad    = in_valid && !onehot;
    // Within a good sample, anything that is not greater is the "le" class.
    assign is_gt  = greater;

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        if (good) begin
            case (state_q)
                IDLE: begin
                    if (is_gt) begin
                        if (SET_N == 4'd1) begin
                            state_d = ALARM;
                            run_d   = 4'd0;
                        end else begin
                            state_d = ARMING;
                            run_d   = 4'd1;
                        end
                    end else begin
                        run_d = 4'd0;
                    end
                end
                ARMING: begin
                    if (is_gt) begin
                        if (run_q + 4'd1 == SET_N) begin
                            state_d = ALARM;
                            run_d   = 4'd0;
                        end else begin
                            run_d = run_q + 4'd1;
                        end
                    end else begin
                        state_d = IDLE;
                        run_d   = 4'd0;
                    end
                end
                ALARM: begin
                    if (!is_gt) begin
                        if (CLR_N == 4'd1) begin
                            state_d = IDLE;
                            run_d   = 4'd0;
                        end else begin
                            state_d = CLEARING;
                            run_d   = 4'd1;
                        end
                    end else begin
                        run_d = 4'd0;
                    end
                end
                CLEARING: begin
                    if (!is_gt) begin
                        if (run_q + 4'd1 == CLR_N) begin
                            state_d = IDLE;
                            run_d   = 4'd0;
                        end else begin
                            run_d = run_q + 4'd1;
                        end
                    end else begin
                        state_d = ALARM;
                        run_d   = 4'd0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    run_d   = 4'd0;
                end
            endcase
        end
    end

    // Only an entry from the non-alarm side counts as a rise; CLEARING->ALARM is a re-assert.
    assign rise_d = (state_d == ALARM) && ((state_q == IDLE) || (state_q == ARMING));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            run_q   <= 4'd0;
            rise_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            rise_q  <= rise_d;
            err_q   <= bad;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            gt_q <= '0;
            lt_q <= '0;
            eq_q <= '0;
        end else if (good) begin
            if (greater) gt_q <= sat_inc(gt_q);
            if (less)    lt_q <= sat_inc(lt_q);
            if (equal)   eq_q <= sat_inc(eq_q);
        end
    end

`ifdef COMP_ALARM_STICKY_EN
    logic seen_q;

    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            seen_q <= 1'b0;
        end else if (rise_d) begin
            seen_q <= 1'b1;
        end
    end

    assign alarm_seen = seen_q;
`else
    assign alarm_seen = 1'b0;
`endif

    assign state      = state_q;
    assign alarm      = (state_q == ALARM) || (state_q == CLEARING);
    assign alarm_rise = rise_q;
    assign err        = err_q;
    assign gt_cnt     = gt_q;
    assign lt_cnt     = lt_q;
    assign eq_cnt     = eq_q;

endmodule

// File: tb/tb_comp_alarm_fsm.sv
// Directed bench for comp_alarm_fsm (SET_CNT=3, CLR_CNT=2, CNT_W=8) with hand-computed expectations.
module tb_comp_alarm_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       less = 1'b0;
    logic       equal = 1'b0;
    logic       greater = 1'b0;
    logic       clr_stats = 1'b0;
    logic       alarm, alarm_rise, err, alarm_seen;
    logic [1:0] state;
    logic [7:0] gt_cnt, lt_cnt, eq_cnt;

    int total = 0;
    int bad = 0;

`ifdef COMP_ALARM_STICKY_EN
    localparam int STICKY = 1;
`else
    localparam int STICKY = 0;
`endif

    comp_alarm_fsm #(.SET_CNT(3), .CLR_CNT(2), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .less(less), .equal(equal),
        .greater(greater), .clr_stats(clr_stats), .alarm(alarm), .alarm_rise(alarm_rise),
        .state(state), .gt_cnt(gt_cnt), .lt_cnt(lt_cnt), .eq_cnt(eq_cnt), .err(err),
        .alarm_seen(alarm_seen)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs {rst, in_valid, less, equal, greater, clr_stats}, sample 1ns after the edge.
    task automatic step(input logic r, input logic v, input logic l, input logic e,
                        input logic g, input logic c);
        rst = r; in_valid = v; less = l; equal = e; greater = g; clr_stats = c;
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0; less = 1'b0; equal = 1'b0; greater = 1'b0; clr_stats = 1'b0;
    endtask

    task automatic gt_s();   step(0, 1, 0, 0, 1, 0); endtask
    task automatic lt_s();   step(0, 1, 1, 0, 0, 0); endtask
    task automatic eq_s();   step(0, 1, 0, 1, 0, 0); endtask
    task automatic idle_s(); step(0, 0, 0, 0, 0, 0); endtask
    task automatic rst_s();  step(1, 0, 0, 0, 0, 0); endtask

    initial begin
        #2;
        // Reset state
        rst_s();
        check("rst_state", state, 0);
        check("rst_alarm", alarm, 0);
        check("rst_rise", alarm_rise, 0);
        check("rst_err", err, 0);
        check("rst_gt", gt_cnt, 0);
        check("rst_lt", lt_cnt, 0);
        check("rst_eq", eq_cnt, 0);
        check("rst_seen", alarm_seen, 0);

        // Interrupted arming: gt, gt, equal, gt
        gt_s();  check("ia1_state", state, 1);
        gt_s();  check("ia2_state", state, 1);
        eq_s();  check("ia3_state", state, 0); check("ia3_alarm", alarm, 0);
        gt_s();  check("ia4_state", state, 1);
        check("ia_gt", gt_cnt, 3);
        check("ia_eq", eq_cnt, 1);

        // Reset mid-ARMING
        rst_s();
        check("rma_state", state, 0);
        check("rma_gt", gt_cnt, 0);
        check("rma_eq", eq_cnt, 0);

        // Debounced raise
        gt_s();  check("r1_state", state, 1); check("r1_alarm", alarm, 0);
        gt_s();  check("r2_state", state, 1); check("r2_rise", alarm_rise, 0);
        gt_s();  check("r3_state", state, 2); check("r3_alarm", alarm, 1);
        check("r3_rise", alarm_rise, 1);
        check("r3_gt", gt_cnt, 3);
        check("r3_seen", alarm_seen, STICKY);
        idle_s(); check("r4_rise", alarm_rise, 0); check("r4_state", state, 2);

        // Hysteresis
        lt_s();  check("h1_state", state, 3); check("h1_alarm", alarm, 1); check("h1_lt", lt_cnt, 1);
        gt_s();  check("h2_state", state, 2); check("h2_rise", alarm_rise, 0); check("h2_gt", gt_cnt, 4);
        lt_s();  check("h3_state", state, 3); check("h3_alarm", alarm, 1);
        lt_s();  check("h4_state", state, 0); check("h4_alarm", alarm, 0); check("h4_lt", lt_cnt, 3);
        check("h4_seen", alarm_seen, STICKY);

        // Bad samples and gaps while ARMING; a leaked sample would shorten the run
        gt_s();  check("b1_state", state, 1); check("b1_gt", gt_cnt, 5);
        step(0, 1, 1, 0, 1, 0);
        check("b2_err", err, 1); check("b2_state", state, 1);
        check("b2_gt", gt_cnt, 5); check("b2_lt", lt_cnt, 3);
        step(0, 1, 0, 0, 0, 0);
        check("b3_err", err, 1); check("b3_state", state, 1);
        step(0, 0, 0, 0, 1, 0);
        check("b4_err", err, 0); check("b4_state", state, 1); check("b4_gt", gt_cnt, 5);
        gt_s();  check("b5_state", state, 1); check("b5_err", err, 0);
        gt_s();  check("b6_state", state, 2); check("b6_rise", alarm_rise, 1); check("b6_gt", gt_cnt, 7);

        // Saturation
        for (int i = 0; i < 300; i++) gt_s();
        check("sat_gt", gt_cnt, 255);
        check("sat_state", state, 2);
        check("sat_rise", alarm_rise, 0);
        check("sat_lt", lt_cnt, 3);

        // Clear together with a greater sample
        step(0, 1, 0, 0, 1, 1);
        check("clr_gt", gt_cnt, 0); check("clr_lt", lt_cnt, 0); check("clr_eq", eq_cnt, 0);
        check("clr_state", state, 2);
        check("clr_seen", alarm_seen, 0);
        gt_s();  check("clr2_gt", gt_cnt, 1);

        // Clear wins over a simultaneous rise on the sticky flag
        rst_s();
        gt_s(); gt_s();
        step(0, 1, 0, 0, 1, 1);
        check("cr_state", state, 2); check("cr_rise", alarm_rise, 1);
        check("cr_seen", alarm_seen, 0); check("cr_gt", gt_cnt, 0);

        // Reset from ALARM
        rst_s();
        check("ra_state", state, 0); check("ra_alarm", alarm, 0);
        check("ra_rise", alarm_rise, 0); check("ra_seen", alarm_seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
